// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one fixed-point divider among NUM_REQ requesters.
// Each requester owns an operand slot; results return on a shared bus with a one-hot done strobe.
//
// state    | meaning
// ST_IDLE  | pick next pending slot round-robin from rr_ptr
// ST_ISSUE | present slot[grant] operands, start divider once it is not busy
// ST_WAIT  | wait for div_done, capture result, strobe req_done next cycle
module div_arbiter #(
  parameter int N       = 22,
  parameter int Q       = 10,
  parameter int NUM_REQ = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_start,
  input  logic [NUM_REQ*N-1:0] req_dividend,
  input  logic [NUM_REQ*N-1:0] req_divisor,
  output logic [NUM_REQ-1:0]   req_busy,
  output logic [NUM_REQ-1:0]   req_done,
  output logic [N-1:0]         res_q,
  output logic                 res_dbz,
  output logic                 res_overflow,
  output logic                 div_start,
  output logic [N-1:0]         div_dividend,
  output logic [N-1:0]         div_divisor,
  input  logic                 div_busy,
  input  logic                 div_done,
  input  logic                 div_dbz,
  input  logic                 div_overflow,
  input  logic [N-1:0]         div_output_q
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW:0] NUM_REQ_W = (PW+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  if (Q >= N || NUM_REQ < 2 || NUM_REQ > 8) begin : g_param_check
    $error("div_arbiter: unsupported parameter combination");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] pick_oh;
  logic [PW-1:0]      grant;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      pick;
  logic [PW:0]        idx;
  logic               found;
  logic [N-1:0]       slot_dividend [NUM_REQ];
  logic [N-1:0]       slot_divisor  [NUM_REQ];

  assign grant_oh = ONE << grant;
  assign pick_oh  = ONE << pick;
  assign req_busy = pending | ((state != ST_IDLE) ? grant_oh : '0);
  assign accept   = req_start & ~req_busy;

  // First pending slot at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
      if (!found && pending[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      ST_IDLE:  if (found) state_nxt = ST_ISSUE;
      ST_ISSUE: if (!div_busy) begin
                  div_start = 1'b1;
                  state_nxt = ST_WAIT;
                end
      ST_WAIT:  if (div_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign div_dividend = (state != ST_IDLE) ? slot_dividend[grant] : '0;
  assign div_divisor  = (state != ST_IDLE) ? slot_divisor[grant]  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      grant        <= '0;
      rr_ptr       <= '0;
      req_done     <= '0;
      res_q        <= '0;
      res_dbz      <= 1'b0;
      res_overflow <= 1'b0;
    end else begin
      req_done <= '0;
      if (state == ST_IDLE && found) begin
        grant   <= pick;
        pending <= (pending | accept) & ~pick_oh;
      end else begin
        pending <= pending | accept;
      end
      // div_done outside ST_WAIT is deliberately ignored
      if (state == ST_WAIT && div_done) begin
        res_q        <= div_output_q;
        res_dbz      <= div_dbz;
        res_overflow <= div_overflow;
        req_done     <= grant_oh;
        rr_ptr       <= (grant == PW'(NUM_REQ-1)) ? '0 : grant + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_dividend[i] <= '0;
        slot_divisor[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          slot_dividend[i] <= req_dividend[i*N +: N];
          slot_divisor[i]  <= req_divisor[i*N +: N];
        end
      end
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: divider stub plus a slot/queue-level reference model of the arbiter.
// Directed scenarios first, then randomized traffic with spurious divider pulses.
module tb_div_arbiter;
  localparam int N  = 22;
  localparam int Q  = 10;
  localparam int NR = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_start;
  logic [NR*N-1:0]   req_dividend, req_divisor;
  logic [NR-1:0]     req_busy, req_done;
  logic [N-1:0]      res_q;
  logic              res_dbz, res_overflow;
  logic              div_start;
  logic [N-1:0]      div_dividend, div_divisor;
  logic              div_busy, div_done, div_dbz, div_overflow;
  logic [N-1:0]      div_output_q;

  always #5 clk = ~clk;

  div_arbiter #(.N(N), .Q(Q), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_start(req_start), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_busy(req_busy), .req_done(req_done),
    .res_q(res_q), .res_dbz(res_dbz), .res_overflow(res_overflow),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_done(div_done), .div_dbz(div_dbz),
    .div_overflow(div_overflow), .div_output_q(div_output_q)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Fixed-point divide reference: returns {dbz, overflow, q}.
  function automatic logic [N+1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
    longint num, qq, lim;
    logic   ovf;
    if (b == '0) return {1'b1, 1'b0, {N{1'b0}}};
    num = longint'($signed(a)) * (longint'(1) << Q);
    qq  = num / longint'($signed(b));
    lim = longint'(1) << (N-1);
    ovf = (qq > lim - 1) || (qq < -lim);
    return {1'b0, ovf, qq[N-1:0]};
  endfunction

  function automatic logic [NR*N-1:0] pack3(input logic [N-1:0] a0, input logic [N-1:0] a1,
                                            input logic [N-1:0] a2);
    return {a2, a1, a0};
  endfunction

  // reference model state
  bit            m_busy [NR];
  bit            m_wait [NR];
  int            m_wait_cyc [NR];
  logic [N-1:0]  m_dvd [NR];
  logic [N-1:0]  m_dvs [NR];
  int            m_rr, m_grant;
  bit            m_free, m_issue_due, m_insvc, m_done_prev;
  logic [N+1:0]  m_exp, m_last;
  // divider stub state
  bit            s_active, done_now, force_busy, spur_en;
  int            s_lat, fixed_lat;
  logic [N-1:0]  s_a, s_b;
  int            last_ds_cyc, ds_count;
  logic [NR-1:0] done_log [$];

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_busy[i] = 0; m_wait[i] = 0; m_wait_cyc[i] = 0; m_dvd[i] = '0; m_dvs[i] = '0;
    end
    m_rr = 0; m_grant = 0; m_free = 1; m_issue_due = 0; m_insvc = 0; m_done_prev = 0;
    m_exp = '0; m_last = '0;
    s_active = 0; done_now = 0; s_lat = 0;
    done_log.delete();
  endtask

  task automatic step(input logic [NR-1:0] st, input logic [NR*N-1:0] dvd,
                      input logic [NR*N-1:0] dvs);
    logic [NR-1:0] exp_busy, exp_done;
    logic [N+1:0]  r;
    logic [N-1:0]  ea, eb;
    bit            found;
    int            idx;
    @(posedge clk); #1;
    cyc++;
    req_start = st; req_dividend = dvd; req_divisor = dvs;
    done_now = 0; div_done = 1'b0;
    if (s_active) begin
      if (s_lat == 0) begin
        r = ref_div(s_a, s_b);
        div_done = 1'b1; div_output_q = r[N-1:0]; div_dbz = r[N+1]; div_overflow = r[N];
        s_active = 0; done_now = 1;
      end else s_lat--;
    end else if (spur_en && $urandom_range(0, 19) == 0) begin
      div_done = 1'b1; div_output_q = N'($urandom);
      div_dbz = 1'($urandom); div_overflow = 1'($urandom);
    end
    div_busy = s_active | done_now | force_busy;

    @(negedge clk);
    exp_done = m_done_prev ? (NR'(1) << m_grant) : '0;
    chk("req_done", 32'(req_done), 32'(exp_done));
    if (req_done != '0) done_log.push_back(req_done);
    if (m_done_prev) begin
      m_last = m_exp; m_busy[m_grant] = 0; m_free = 1; m_insvc = 0;
      m_rr = (m_grant + 1) % NR;
    end
    chk("res_q", 32'(res_q), 32'(m_last[N-1:0]));
    chk("res_dbz", 32'(res_dbz), 32'(m_last[N+1]));
    chk("res_overflow", 32'(res_overflow), 32'(m_last[N]));
    for (int i = 0; i < NR; i++) exp_busy[i] = m_busy[i];
    chk("req_busy", 32'(req_busy), 32'(exp_busy));

    ea = '0; eb = '0;
    if (m_issue_due || m_insvc) begin ea = m_dvd[m_grant]; eb = m_dvs[m_grant]; end
    chk("div_dividend", 32'(div_dividend), 32'(ea));
    chk("div_divisor", 32'(div_divisor), 32'(eb));
    if (m_issue_due) chk("div_start", 32'(div_start), 32'(!div_busy));
    else             chk("div_start_idle", 32'(div_start), 32'(0));
    if (div_start) begin
      last_ds_cyc = cyc; ds_count++;
      if (m_issue_due) begin
        m_issue_due = 0; m_insvc = 1;
        m_exp = ref_div(m_dvd[m_grant], m_dvs[m_grant]);
      end
      s_active = 1; s_a = div_dividend; s_b = div_divisor;
      s_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
    end

    for (int i = 0; i < NR; i++) begin
      if (st[i] && !m_busy[i]) begin
        m_busy[i] = 1; m_wait[i] = 1; m_wait_cyc[i] = cyc;
        m_dvd[i] = dvd[i*N +: N]; m_dvs[i] = dvs[i*N +: N];
      end
    end
    // a start only becomes visible to arbitration on the cycle after it is captured
    found = 0;
    if (m_free) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_rr + k) % NR;
        if (!found && m_wait[idx] && m_wait_cyc[idx] < cyc) begin
          found = 1; m_grant = idx; m_wait[idx] = 0; m_free = 0; m_issue_due = 1;
        end
      end
    end
    m_done_prev = done_now;
  endtask

  task automatic idle_step();
    step('0, '0, '0);
  endtask

  task automatic drain();
    bit idle;
    for (int i = 0; i < 400; i++) begin
      idle = m_free && !s_active;
      for (int j = 0; j < NR; j++) if (m_busy[j]) idle = 0;
      if (idle) return;
      idle_step();
    end
    chk("drain_timeout", 32'(1), 32'(0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(req_busy), 32'(0));
    chk({tag, "_done"}, 32'(req_done), 32'(0));
    chk({tag, "_res"}, 32'({res_q, res_dbz, res_overflow}), 32'(0));
    chk({tag, "_divout"}, 32'({div_start, div_dividend}), 32'(0));
    chk({tag, "_divisor"}, 32'(div_divisor), 32'(0));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    req_start = '0; div_done = 1'b0; div_busy = 1'b0; force_busy = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  int c0;

  initial begin
    rst_n = 1'b0; req_start = '0; req_dividend = '0; req_divisor = '0;
    div_busy = 1'b0; div_done = 1'b0; div_dbz = 1'b0; div_overflow = 1'b0; div_output_q = '0;
    force_busy = 0; spur_en = 0; fixed_lat = -1; last_ds_cyc = 0; ds_count = 0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset("rst");

    // single request: 3.0 / 2.0
    step(3'b001, pack3(22'h000C00, '0, '0), pack3(22'h000800, '0, '0));
    c0 = cyc;
    drain();
    chk("t1_start_lat", 32'(last_ds_cyc - c0), 32'(2));
    chk("t1_ndone", 32'(done_log.size()), 32'(1));
    if (done_log.size() == 1) chk("t1_done", 32'(done_log[0]), 32'(3'b001));
    chk("t1_q", 32'(res_q), 32'(22'h000600));
    chk("t1_dbz", 32'(res_dbz), 32'(0));

    // round robin from a fresh pointer
    do_reset("rst2");
    step(3'b111, pack3(22'h001400, 22'h002800, 22'h3FF000), pack3(22'h000400, 22'h000800, 22'h000C00));
    drain();
    chk("t2_n", 32'(done_log.size()), 32'(3));
    if (done_log.size() == 3) begin
      chk("t2_o0", 32'(done_log[0]), 32'(3'b001));
      chk("t2_o1", 32'(done_log[1]), 32'(3'b010));
      chk("t2_o2", 32'(done_log[2]), 32'(3'b100));
    end
    step(3'b010, pack3('0, 22'h000400, '0), pack3('0, 22'h000400, '0));
    drain();
    done_log.delete();
    step(3'b101, pack3(22'h000800, '0, 22'h000C00), pack3(22'h000400, '0, 22'h000400));
    drain();
    chk("t2b_n", 32'(done_log.size()), 32'(2));
    if (done_log.size() == 2) begin
      chk("t2b_o0", 32'(done_log[0]), 32'(3'b100));
      chk("t2b_o1", 32'(done_log[1]), 32'(3'b001));
    end

    // divide by zero on slot 1
    done_log.delete();
    step(3'b010, pack3('0, 22'h001000, '0), '0);
    drain();
    chk("t3_done", 32'(done_log.size() == 1 ? done_log[0] : 3'b000), 32'(3'b010));
    chk("t3_dbz", 32'(res_dbz), 32'(1));
    idle_step();
    chk("t3_free", 32'(req_busy[1]), 32'(0));

    // second start on a pending slot is dropped
    done_log.delete();
    step(3'b100, pack3('0, '0, 22'h001800), pack3('0, '0, 22'h000800));
    step(3'b100, pack3('0, '0, 22'h000400), pack3('0, '0, 22'h000400));
    drain();
    chk("t4_ndone", 32'(done_log.size()), 32'(1));
    chk("t4_q", 32'(res_q), 32'(22'h000C00));

    // divider held busy during ISSUE
    ds_count = 0;
    force_busy = 1;
    step(3'b001, pack3(22'h000C00, '0, '0), pack3(22'h000400, '0, '0));
    c0 = cyc;
    repeat (6) idle_step();
    force_busy = 0;
    drain();
    chk("t5_ds_cnt", 32'(ds_count), 32'(1));
    chk("t5_ds_cyc", 32'(last_ds_cyc - c0), 32'(7));

    // reset while waiting on the divider
    fixed_lat = 20;
    step(3'b001, pack3(22'h000400, '0, '0), pack3(22'h000400, '0, '0));
    for (int i = 0; i < 10 && !m_insvc; i++) idle_step();
    chk("t6_in_wait", 32'(m_insvc), 32'(1));
    repeat (2) idle_step();
    do_reset("t6_rst");
    fixed_lat = -1;
    repeat (5) idle_step();
    chk("t6_no_done", 32'(done_log.size()), 32'(0));
    step(3'b001, pack3(22'h000A00, '0, '0), pack3(22'h000400, '0, '0));
    drain();
    chk("t6_after", 32'(done_log.size() == 1 ? done_log[0] : 3'b000), 32'(3'b001));
    chk("t6_q", 32'(res_q), 32'(22'h000A00));

    // randomized traffic with spurious divider pulses
    spur_en = 1;
    for (int i = 0; i < 800; i++) begin
      logic [NR*N-1:0] a, b;
      for (int s = 0; s < NR; s++) begin
        a[s*N +: N] = N'($urandom);
        b[s*N +: N] = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom >> $urandom_range(0, 20));
      end
      step(NR'($urandom) & NR'($urandom), a, b);
    end
    spur_en = 0;
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Round-robin arbiter that shares one fixed-point divider instance among NUM_REQ requesters.
- Each requester has a private operand slot. The arbiter serialises slots into the divider's start/done handshake and returns results on a shared bus with a one-hot completion strobe.
- Sits between the compute sequencers and the divider. The divider's dbz/overflow flags are passed through per transaction.

Parameters:
- N, 22, total fixed-point width (two's complement).
- Q, 10, fractional bits. Pass-through only; no arithmetic is done here.
- NUM_REQ, 3, number of requesters (2..8).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_start  in  NUM_REQ  per-requester 1-cycle start pulse.
- req_dividend  in  NUM_REQ*N  packed dividends; slot i at [i*N +: N].
- req_divisor  in  NUM_REQ*N  packed divisors; slot i at [i*N +: N].
- req_busy  out  NUM_REQ  slot i pending or in service.
- req_done  out  NUM_REQ  one-hot 1-cycle completion strobe.
- res_q  out  N  result of the completed transaction (signed).
- res_dbz  out  1  divide-by-zero flag of the completed transaction.
- res_overflow  out  1  overflow flag of the completed transaction.
- div_start  out  1  1-cycle start to the divider.
- div_dividend  out  N  operand to the divider.
- div_divisor  out  N  operand to the divider.
- div_busy  in  1  divider busy.
- div_done  in  1  divider 1-cycle done pulse.
- div_dbz  in  1  divider divide-by-zero flag, valid with div_done.
- div_overflow  in  1  divider overflow flag, valid with div_done.
- div_output_q  in  N  divider result, valid with div_done.

Behaviour:
- Reset values:
  - All outputs 0.
  - All slots empty; rr_ptr = 0; grant = 0; state = IDLE.
- Slot capture:
  - req_start[i] with slot i empty latches both operands and sets pending[i] on the next edge.
  - req_busy[i] = pending[i] OR (state != IDLE AND grant == i).
  - req_start[i] while req_busy[i] is silently ignored; latched operands are unchanged.
- FSM IDLE:
  - If any pending bit is set, grant = first set index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Clear pending[grant]; go to ISSUE.
  - Uses registered pending only, so a start arriving in this cycle is considered next cycle.
- FSM ISSUE:
  - If div_busy = 1, hold in ISSUE with div_start = 0.
  - Otherwise assert div_start for exactly this cycle, with div_dividend/div_divisor driven from slot grant; go to WAIT.
  - div_dividend/div_divisor hold the slot-grant values from ISSUE through WAIT; they are 0 in IDLE.
- FSM WAIT:
  - On div_done, register res_q, res_dbz and res_overflow from the divider.
  - Pulse req_done[grant] on the following cycle, coincident with the new res_* values.
  - rr_ptr = (grant+1) mod NUM_REQ; return to IDLE.
  - res_* hold their values until the next completion.
- Latency:
  - Start pulse to div_start = 2 cycles when the divider is idle and no other slot is ahead.
  - div_done to req_done = 1 cycle.
  - Back-to-back grants are separated by one IDLE cycle.
- Fairness: a requester that re-requests immediately after its own req_done waits behind every other pending slot.
- Simultaneous events:
  - Multiple starts in one cycle are all captured.
  - A start on the slot being completed, in the same cycle as div_done, is ignored because req_busy is still 1.
  - A start on the slot in the cycle req_done pulses is accepted.
- Asynchronous reset mid-transaction:
  - Returns to the reset state immediately; no req_done is issued.
  - The divider is reset by the same rst_n.
- Spurious div_done outside WAIT is ignored.

Test Plan:
- Single request: reset, then req_start[0] with dividend 0x000C00 (3.0) and divisor 0x000800 (2.0). Required: div_start 2 cycles later; after div_done, req_done = 3'b001 with res_q = 0x000600 (1.5) and res_dbz = 0.
- Round-robin: all three starts in one cycle. Required: grant order 0,1,2 and req_done order 001, 010, 100. Then re-request slots 0 and 2 after slot 1 last completed: order 2 then 0.
- Divide by zero: slot 1 with divisor 0. Required: req_done = 3'b010 with res_dbz = 1; slot 1 is free on the next cycle.
- Busy drop: second req_start[2] while slot 2 is pending, with different operands. Required: ignored; the result reflects the first operands; exactly one req_done[2].
- Divider held busy: div_busy forced high during ISSUE for 5 cycles. Required: div_start deferred until div_busy = 0, then asserted for exactly 1 cycle.
- Reset mid-WAIT: assert rst_n = 0 during WAIT. Required: all outputs 0 asynchronously, no req_done issued, and a new request after release completes normally.
